// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Instruction prefetch queue between fetch and decode.
//                Circular buffer of {pc, inst} pairs with valid/ready
//                handshakes on both sides and a single-cycle flush that
//                discards every buffered entry on a redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module inst_queue #(
   parameter int DEPTH = 4,   // power of 2, >= 2
   parameter int PTR_W = 2,   // log2(DEPTH)
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_inst,
   output logic [PTR_W:0]   count
);

   // Occupancy value meaning "every slot holds an entry".
   localparam logic [PTR_W:0] C_FULL_COUNT = (PTR_W+1)'(DEPTH);

   // Storage: contents are never reset; only the pointers/count define validity.
   logic [WIDTH-1:0] r_mem_pc   [0:DEPTH-1];
   logic [WIDTH-1:0] r_mem_inst [0:DEPTH-1];

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W:0]   w_count_nxt;

   // Status flags come only from registered occupancy, so in_ready never
   // depends on out_ready (a full queue refuses a push even while popping).
   always_comb begin
      w_full  = (r_count == C_FULL_COUNT);
      w_empty = (r_count == '0);
   end

   // Handshake qualification; flush suppresses both sides in its cycle.
   always_comb begin
      w_push = in_valid  & ~w_full  & ~flush;
      w_pop  = ~w_empty  & out_ready & ~flush;
   end

   // Occupancy update: simultaneous push and pop leave the count unchanged.
   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointer and occupancy registers; flush returns the queue to its reset
   // state so the next accepted entry lands in slot 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
      end
   end

   // One write-enabled register pair per slot; a refused push writes nothing.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic w_slot_we;

         // Slot write enable: accepted push aimed at this slot.
         always_comb begin
            w_slot_we = w_push & (r_wr_ptr == PTR_W'(gi));
         end

         // Capture the offered pair into this slot.
         always_ff @(posedge clk) begin
            if (w_slot_we) begin
               r_mem_pc[gi]   <= in_pc;
               r_mem_inst[gi] <= in_inst;
            end
         end
      end
   endgenerate

   // Head presentation; outputs are forced to zero while empty so that
   // stale storage never leaks onto the decode interface.
   always_comb begin
      in_ready  = ~w_full;
      out_valid = ~w_empty;
      count     = r_count;
      out_pc    = '0;
      out_inst  = '0;
      if (!w_empty) begin
         out_pc   = r_mem_pc[r_rd_ptr];
         out_inst = r_mem_inst[r_rd_ptr];
      end
   end

endmodule
`default_nettype wire
